led_bank_scheduler: RTL and testbench

- Time-shares the board's single 8-bit LED bank between three pattern requesters, for example a chaser, a blink-all generator and a status display.
- Arbitration is round-robin. Each grant holds for a minimum dwell time measured in ticks of a built-in prescaler from the 50 MHz clock.
- Sits between the pattern generators and the LED pins. It drives LED_Output, grant and the shared tick strobe.

---
 rtl/led_pkg.sv | 25 ++
 rtl/led_bank_scheduler_if.sv | 36 +++
 rtl/led_tick_gen.sv | 47 ++++
 rtl/led_bank_scheduler.sv | 150 +++++++++++++++
 tb/tb_led_bank_scheduler.sv | 267 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/led_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : led_pkg
//  Purpose  : Shared definitions for the LED bank scheduler and the pattern
//             generators that sit around it: default LED bank width, the
//             default prescaler divide for 50 MHz -> 8 Hz, and the scheduler
//             state encoding.
//  Ports    : none (package)
//  Revision : 1.0 - initial release
// ============================================================================
package led_pkg;

  // Default LED bank width (the board has a single 8-bit bank).
  localparam int LED_W_DEFAULT = 8;

  // 50 MHz / 6_250_000 = 8 Hz tick.
  localparam int TICK_DIV_DEFAULT = 6_250_000;

  typedef enum logic [0:0] {
    ST_IDLE  = 1'b0,
    ST_GRANT = 1'b1
  } sched_state_e;

endpackage
`default_nettype wire

// File: rtl/led_bank_scheduler_if.sv
`default_nettype none
// ============================================================================
//  Module   : led_bank_scheduler_if
//  Purpose  : Bundles the requester side (req, pat0..pat2) and the LED side
//             (grant, LED_Output, tick, busy) of the LED bank scheduler.
//  Ports    : master - pattern-generator side: drives req/pat*, sees
//                      grant/LED_Output/tick/busy
//             slave  - scheduler side: the reverse
//  Revision : 1.0 - initial release
// ============================================================================
interface led_bank_scheduler_if #(
  parameter int LED_W = led_pkg::LED_W_DEFAULT
) ();
  import led_pkg::*;

  logic [2:0]       req;
  logic [LED_W-1:0] pat0;
  logic [LED_W-1:0] pat1;
  logic [LED_W-1:0] pat2;
  logic [2:0]       grant;
  logic [LED_W-1:0] LED_Output;
  logic             tick;
  logic             busy;

  modport master (
    output req, pat0, pat1, pat2,
    input  grant, LED_Output, tick, busy
  );

  modport slave (
    input  req, pat0, pat1, pat2,
    output grant, LED_Output, tick, busy
  );

endinterface
`default_nettype wire

// File: rtl/led_tick_gen.sv
`default_nettype none
// ============================================================================
//  Module   : led_tick_gen
//  Purpose  : Free-running prescaler 0..TICK_DIV-1 with a registered
//             one-cycle tick strobe, high exactly while the prescaler sits
//             at TICK_DIV-1. Shared pacing for the scheduler and generators.
//  Ports    : clk   in  1  rising-edge clock
//             rst_n in  1  synchronous active-low reset
//             tick  out 1  one-cycle strobe every TICK_DIV cycles
//  Revision : 1.0 - initial release
// ============================================================================
module led_tick_gen
  import led_pkg::*;
#(
  parameter int TICK_DIV = TICK_DIV_DEFAULT
) (
  input  logic clk,
  input  logic rst_n,
  output logic tick
);

  localparam int PW = $clog2(TICK_DIV);
  localparam logic [PW-1:0] c_presc_last = PW'(TICK_DIV - 1);

  logic [PW-1:0] presc_q, presc_d;
  logic          tick_q,  tick_d;

  always_comb begin
    presc_d = (presc_q == c_presc_last) ? '0 : presc_q + PW'(1);
    // Register the strobe so it coincides with presc_q == TICK_DIV-1.
    tick_d  = (presc_d == c_presc_last);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      presc_q <= '0;
      tick_q  <= 1'b0;
    end else begin
      presc_q <= presc_d;
      tick_q  <= tick_d;
    end
  end

  assign tick = tick_q;

endmodule
`default_nettype wire

// File: rtl/led_bank_scheduler.sv
`default_nettype none
// ============================================================================
//  Module   : led_bank_scheduler
//  Purpose  : Round-robin time-sharing of one LED bank between three pattern
//             requesters, with a minimum dwell (in prescaler ticks) before a
//             waiting requester can take the bank from a current owner.
//  Ports    : Clk_50MHz     in  1      system clock, rising edge
//             Reset_Onboard in  1      synchronous active-low reset
//             bus (slave)   req[2:0], pat0/1/2 in; grant[2:0] one-hot owner,
//                           LED_Output registered pins, tick strobe,
//                           busy (high while a requester owns the bank) out
//  Revision : 1.0 - initial release
// ============================================================================
module led_bank_scheduler
  import led_pkg::*;
#(
  parameter int TICK_DIV    = TICK_DIV_DEFAULT,
  parameter int DWELL_TICKS = 16,
  parameter int LED_W       = LED_W_DEFAULT
) (
  input  logic            Clk_50MHz,
  input  logic            Reset_Onboard,
  led_bank_scheduler_if.slave bus
);

  localparam int DW = $clog2(DWELL_TICKS + 1);
  localparam logic [DW-1:0] c_dwell_max = DW'(DWELL_TICKS);

  // Search last+1, last+2, then last itself; caller guarantees r != 0.
  function automatic logic [1:0] rr_pick(input logic [2:0] r, input logic [1:0] last);
    logic [1:0] n1;
    logic [1:0] n2;
    n1 = (last == 2'd2) ? 2'd0 : last + 2'd1;
    n2 = (n1 == 2'd2) ? 2'd0 : n1 + 2'd1;
    if (r[n1])      rr_pick = n1;
    else if (r[n2]) rr_pick = n2;
    else            rr_pick = last;
  endfunction

  function automatic logic [2:0] onehot3(input logic [1:0] idx);
    onehot3 = 3'b001 << idx;
  endfunction

  function automatic logic [LED_W-1:0] pat_sel(input logic [1:0] idx,
                                               input logic [LED_W-1:0] p0,
                                               input logic [LED_W-1:0] p1,
                                               input logic [LED_W-1:0] p2);
    case (idx)
      2'd0:    pat_sel = p0;
      2'd1:    pat_sel = p1;
      default: pat_sel = p2;
    endcase
  endfunction

  sched_state_e     state_q, state_d;
  logic [2:0]       grant_q, grant_d;
  logic [LED_W-1:0] led_q,   led_d;
  logic [1:0]       last_q,  last_d;   // also the current owner while in GRANT
  logic [DW-1:0]    dwell_q, dwell_d;

  logic             w_tick;
  logic [2:0]       w_others;
  logic [1:0]       w_pick;
  logic             w_held;
  logic             w_expired;

  led_tick_gen #(
    .TICK_DIV (TICK_DIV)
  ) u_tick_gen (
    .clk   (Clk_50MHz),
    .rst_n (Reset_Onboard),
    .tick  (w_tick)
  );

  always_comb begin
    state_d   = state_q;
    grant_d   = grant_q;
    led_d     = led_q;
    last_d    = last_q;
    dwell_d   = dwell_q;
    w_others  = bus.req & ~grant_q;
    w_pick    = last_q;
    w_held    = bus.req[last_q];
    w_expired = (dwell_q == c_dwell_max);

    case (state_q)
      ST_IDLE: begin
        grant_d = '0;
        led_d   = '0;
        dwell_d = '0;
        if (bus.req != 3'b000) begin
          w_pick  = rr_pick(bus.req, last_q);
          state_d = ST_GRANT;
          grant_d = onehot3(w_pick);
          last_d  = w_pick;
          led_d   = pat_sel(w_pick, bus.pat0, bus.pat1, bus.pat2);
        end
      end

      ST_GRANT: begin
        // Release or expiry with a waiter: hand over on this edge. The
        // owner bit is masked out, so the pick never re-selects the owner.
        if ((!w_held || w_expired) && (w_others != 3'b000)) begin
          w_pick  = rr_pick(w_others, last_q);
          grant_d = onehot3(w_pick);
          last_d  = w_pick;
          dwell_d = '0;
          led_d   = pat_sel(w_pick, bus.pat0, bus.pat1, bus.pat2);
        end else if (!w_held) begin
          state_d = ST_IDLE;
          grant_d = '0;
          led_d   = '0;
          dwell_d = '0;
        end else begin
          led_d = pat_sel(last_q, bus.pat0, bus.pat1, bus.pat2);
          if (w_tick && !w_expired) begin
            dwell_d = dwell_q + DW'(1);
          end
        end
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge Clk_50MHz) begin
    if (!Reset_Onboard) begin
      state_q <= ST_IDLE;
      grant_q <= '0;
      led_q   <= '0;
      last_q  <= 2'd2;
      dwell_q <= '0;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      led_q   <= led_d;
      last_q  <= last_d;
      dwell_q <= dwell_d;
    end
  end

  assign bus.grant      = grant_q;
  assign bus.LED_Output = led_q;
  assign bus.tick       = w_tick;
  assign bus.busy       = (state_q == ST_GRANT);

endmodule
`default_nettype wire

// File: tb/tb_led_bank_scheduler.sv
`default_nettype none
// ============================================================================
//  Module   : tb_led_bank_scheduler
//  Purpose  : Self-checking bench for led_bank_scheduler (TICK_DIV=4,
//             DWELL_TICKS=2) against a behavioural model of the arbitration
//             rules, plus directed checks of the documented scenarios.
//  Ports    : none
//  Revision : 1.0 - initial release
// ============================================================================
module tb_led_bank_scheduler;
  import led_pkg::*;

  localparam int TICK_DIV = 4;
  localparam int DWELL    = 2;
  localparam int LW       = 8;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;

  always #5 clk = ~clk;

  led_bank_scheduler_if #(.LED_W(LW)) bus ();

  led_bank_scheduler #(
    .TICK_DIV    (TICK_DIV),
    .DWELL_TICKS (DWELL),
    .LED_W       (LW)
  ) dut (
    .Clk_50MHz     (clk),
    .Reset_Onboard (rst_n),
    .bus           (bus)
  );

  int n_cmp = 0;
  int n_err = 0;

  // Reference model state: owner -1 means idle.
  int       m_presc = 0;
  bit       m_tick  = 1'b0;
  int       m_owner = -1;
  int       m_last  = 2;
  int       m_dwell = 0;
  logic [7:0] m_led = 8'h00;

  function automatic int pick(input int r, input int last);
    for (int k = 1; k <= 3; k++) begin
      int c;
      c = (last + k) % 3;
      if (((r >> c) & 1) != 0) return c;
    end
    return -1;
  endfunction

  function automatic logic [7:0] pat_of(input int w);
    if (w == 0) return bus.pat0;
    if (w == 1) return bus.pat1;
    return bus.pat2;
  endfunction

  function automatic void take(input int w);
    m_owner = w;
    m_last  = w;
    m_dwell = 0;
    m_led   = pat_of(w);
  endfunction

  // Advance the model across one rising edge using the inputs present there.
  function automatic void model_edge();
    int r;
    int others;
    bit held;
    bit tick_now;
    r = int'(bus.req);
    if (!rst_n) begin
      m_presc = 0;
      m_tick  = 1'b0;
      m_owner = -1;
      m_last  = 2;
      m_dwell = 0;
      m_led   = 8'h00;
    end else begin
      tick_now = m_tick;
      m_presc  = (m_presc + 1) % TICK_DIV;
      m_tick   = (m_presc == TICK_DIV - 1);
      if (m_owner < 0) begin
        if (r != 0) take(pick(r, m_last));
      end else begin
        held   = ((r >> m_owner) & 1) != 0;
        others = r & ~(1 << m_owner);
        if ((!held || m_dwell == DWELL) && others != 0) begin
          take(pick(others, m_last));
        end else if (!held) begin
          m_owner = -1;
          m_led   = 8'h00;
          m_dwell = 0;
        end else begin
          m_led = pat_of(m_owner);
          if (tick_now && m_dwell < DWELL) m_dwell++;
        end
      end
    end
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp)
    else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_all();
    chk("grant", 32'(bus.grant), (m_owner < 0) ? 32'd0 : 32'(1 << m_owner));
    chk("led",   32'(bus.LED_Output), 32'(m_led));
    chk("tick",  32'(bus.tick), 32'(m_tick));
    chk("busy",  32'(bus.busy), (m_owner >= 0) ? 32'd1 : 32'd0);
  endtask

  task automatic step();
    @(posedge clk);
    model_edge();
    #1;
    check_all();
  endtask

  initial begin
    logic [2:0] seen[$];
    logic [2:0] prev;
    bit         found;
    bit         prev_tick;
    int         cyc;
    int         prev_t;
    int         n_periods;

    bus.req  = 3'b111;
    bus.pat0 = 8'h11;
    bus.pat1 = 8'h22;
    bus.pat2 = 8'h44;
    rst_n    = 1'b0;

    // Reset held for three edges with every requester asserted.
    repeat (3) step();
    chk("rst_grant", 32'(bus.grant), 32'd0);
    chk("rst_led",   32'(bus.LED_Output), 32'd0);
    chk("rst_tick",  32'(bus.tick), 32'd0);
    chk("rst_busy",  32'(bus.busy), 32'd0);

    rst_n = 1'b1;
    step();
    chk("rel_grant", 32'(bus.grant), 32'h1);
    chk("rel_led",   32'(bus.LED_Output), 32'h11);

    // Sole owner keeps the bank; LED tracks its pattern one edge later.
    bus.req  = 3'b001;
    bus.pat0 = 8'hA5;
    step();
    chk("sole_led", 32'(bus.LED_Output), 32'hA5);
    for (int i = 0; i < 40; i++) begin
      step();
      chk("sole_grant", 32'(bus.grant), 32'h1);
    end
    bus.pat0 = 8'h3C;
    step();
    chk("pat_track", 32'(bus.LED_Output), 32'h3C);

    // Rotation through all three requesters.
    bus.req  = 3'b111;
    bus.pat0 = 8'h01;
    bus.pat1 = 8'h02;
    bus.pat2 = 8'h04;
    prev = bus.grant;
    for (int i = 0; i < 200 && seen.size() < 3; i++) begin
      step();
      if (bus.grant !== prev) begin
        seen.push_back(bus.grant);
        prev = bus.grant;
      end
    end
    while (seen.size() < 3) seen.push_back(3'bxxx);
    chk("rot_0", 32'(seen[0]), 32'h2);
    chk("rot_1", 32'(seen[1]), 32'h4);
    chk("rot_2", 32'(seen[2]), 32'h1);

    // Early release: requester 1 drops right after gaining the bank.
    found = 1'b0;
    for (int i = 0; i < 100; i++) begin
      step();
      if (bus.grant === 3'b010) begin
        found = 1'b1;
        break;
      end
    end
    chk("wait_own1", 32'(found), 32'd1);
    bus.req = 3'b100;
    step();
    chk("early_grant", 32'(bus.grant), 32'h4);
    chk("early_led",   32'(bus.LED_Output), 32'h04);
    bus.req = 3'b000;
    step();
    chk("idle_grant", 32'(bus.grant), 32'd0);
    chk("idle_led",   32'(bus.LED_Output), 32'd0);
    chk("idle_busy",  32'(bus.busy), 32'd0);

    // Tick cadence while grants come and go.
    cyc       = 0;
    prev_t    = -1;
    prev_tick = 1'b0;
    n_periods = 0;
    for (int i = 0; i < 60; i++) begin
      if (i % 6 == 0) bus.req = 3'($urandom_range(0, 7));
      step();
      cyc++;
      if (prev_tick) chk("tick_width", 32'(bus.tick), 32'd0);
      if (bus.tick === 1'b1) begin
        if (prev_t >= 0) begin
          chk("tick_period", 32'(cyc - prev_t), 32'd4);
          n_periods++;
        end
        prev_t = cyc;
      end
      prev_tick = bus.tick;
    end
    chk("tick_seen", 32'(n_periods >= 10), 32'd1);

    // Mid-grant reset with requester 2 owning at dwell 1.
    bus.req = 3'b000;
    step();
    bus.req = 3'b100;
    found = 1'b0;
    for (int i = 0; i < 50; i++) begin
      step();
      if (m_owner == 2 && m_dwell == 1) begin
        found = 1'b1;
        break;
      end
    end
    chk("wait_dwell1", 32'(found), 32'd1);
    rst_n = 1'b0;
    step();
    chk("mrst_grant", 32'(bus.grant), 32'd0);
    chk("mrst_led",   32'(bus.LED_Output), 32'd0);
    chk("mrst_tick",  32'(bus.tick), 32'd0);
    chk("mrst_busy",  32'(bus.busy), 32'd0);
    rst_n   = 1'b1;
    bus.req = 3'b110;
    step();
    chk("post_rst_grant", 32'(bus.grant), 32'h2);
    chk("post_rst_led",   32'(bus.LED_Output), 32'h02);

    // Randomised traffic against the model, with occasional resets.
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 3) == 0) bus.req = 3'($urandom_range(0, 7));
      bus.pat0 = 8'($urandom);
      bus.pat1 = 8'($urandom);
      bus.pat2 = 8'($urandom);
      rst_n    = ($urandom_range(0, 63) != 0);
      step();
    end
    rst_n = 1'b1;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
`default_nettype wire
